// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one combinational ALU between two requesters over valid/ready channels.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_req_arbiter #(
    parameter int W = 4,
    parameter int SEL_W = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_A,
    input  logic [W-1:0]     req0_B,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_A,
    input  logic [W-1:0]     req1_B,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_Y,
    output logic             rsp_carry,
    output logic [W-1:0]     alu_A,
    output logic [W-1:0]     alu_B,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [W-1:0]     alu_Y,
    input  logic             alu_carry,
    output logic             busy
);
    localparam int CW = $clog2(EXEC_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state;
    logic [W-1:0]     op_a, op_b;
    logic [SEL_W-1:0] op_sel;
    logic [CW-1:0]    cnt;
    logic             grant, hs;
`ifdef ALU_ARB_RR_EN
    logic last;
    assign grant = (req0_valid && req1_valid) ? !last : !req0_valid;
    always_ff @(posedge clk) begin
        if (rst) last <= 1'b1;
        else if (hs) last <= grant;
    end
`else
    assign grant = !req0_valid;
`endif
    assign req0_ready = !rst && state == IDLE && !grant && req0_valid;
    assign req1_ready = !rst && state == IDLE && grant && req1_valid;
    assign hs = req0_ready || req1_ready;
    // op regs only change on a request handshake, so the ALU inputs hold outside EXEC
    assign alu_A = op_a;
    assign alu_B = op_b;
    assign alu_sel = op_sel;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            cnt       <= '0;
            rsp_id    <= 1'b0;
            rsp_Y     <= '0;
            rsp_carry <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    op_a   <= grant ? req1_A : req0_A;
                    op_b   <= grant ? req1_B : req0_B;
                    op_sel <= grant ? req1_sel : req0_sel;
                    rsp_id <= grant;
                    cnt    <= CW'(EXEC_CYCLES - 1);
                    busy   <= 1'b1;
                    state  <= EXEC;
                end
                EXEC: if (cnt == '0) begin
                    rsp_Y     <= alu_Y;
                    rsp_carry <= alu_carry;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: two instances (EXEC_CYCLES 1 and 3) checked every cycle against a
// transaction-level model, plus directed literal checks.
module tb_alu_req_arbiter;
    logic clk = 1'b0, rst = 1'b1, rr = 1'b1;
    logic v0 = 1'b0, v1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0] s0 = '0, s1 = '0;
    logic rdy0 [2], rdy1 [2], rv [2], rid [2], rc [2], bz [2], ac [2];
    logic [3:0] ry [2], aa [2], ab [2], ay [2];
    logic [2:0] asl [2];
    int pass = 0, total = 0, cyc = 0;
    bit model_ok = 0;
    bit have [2], mid [2], mlast [2];
    int acc [2];
    logic [3:0] ma [2], mb [2];
    logic [2:0] msel [2];

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] s);
        case (s)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        alu_req_arbiter #(.W(4), .SEL_W(3), .EXEC_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk(clk), .rst(rst),
            .req0_valid(v0), .req0_ready(rdy0[g]), .req0_A(a0), .req0_B(b0), .req0_sel(s0),
            .req1_valid(v1), .req1_ready(rdy1[g]), .req1_A(a1), .req1_B(b1), .req1_sel(s1),
            .rsp_valid(rv[g]), .rsp_ready(rr), .rsp_id(rid[g]), .rsp_Y(ry[g]), .rsp_carry(rc[g]),
            .alu_A(aa[g]), .alu_B(ab[g]), .alu_sel(asl[g]), .alu_Y(ay[g]), .alu_carry(ac[g]),
            .busy(bz[g]));
        assign {ac[g], ay[g]} = alu_f(aa[g], ab[g], asl[g]);
    end

    function automatic int ec(int i);
        return i == 0 ? 1 : 3;
    endfunction

    function automatic bit mgrant(int i);
`ifdef ALU_ARB_RR_EN
        if (v0 && v1) return !mlast[i];
`endif
        return !v0;
    endfunction

    function automatic bit e_rdy0(int i);
        return !rst && !have[i] && v0 && !mgrant(i);
    endfunction

    function automatic bit e_rdy1(int i);
        return !rst && !have[i] && v1 && mgrant(i);
    endfunction

    function automatic bit e_rv(int i);
        return have[i] && cyc >= acc[i] + ec(i) + 1;
    endfunction

    task automatic chk(string name, int i, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_ok = 1;
            for (int i = 0; i < 2; i++) begin
                have[i] = 0; mid[i] = 0; mlast[i] = 1;
                ma[i] = '0; mb[i] = '0; msel[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!have[i]) begin
                    if (e_rdy0(i) || e_rdy1(i)) begin
                        bit g;
                        g = mgrant(i);
                        have[i] = 1; acc[i] = cyc; mid[i] = g; mlast[i] = g;
                        ma[i] = g ? a1 : a0; mb[i] = g ? b1 : b0; msel[i] = g ? s1 : s0;
                    end
                end else if (e_rv(i) && rr) begin
                    have[i] = 0;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                logic [4:0] r;
                r = alu_f(ma[i], mb[i], msel[i]);
                chk("req0_ready", i, 8'(rdy0[i]), 8'(e_rdy0(i)));
                chk("req1_ready", i, 8'(rdy1[i]), 8'(e_rdy1(i)));
                chk("rsp_valid", i, 8'(rv[i]), 8'(e_rv(i)));
                chk("busy", i, 8'(bz[i]), 8'(have[i]));
                chk("alu_A", i, 8'(aa[i]), 8'(ma[i]));
                chk("alu_B", i, 8'(ab[i]), 8'(mb[i]));
                chk("alu_sel", i, 8'(asl[i]), 8'(msel[i]));
                if (e_rv(i)) begin
                    chk("rsp_id", i, 8'(rid[i]), 8'(mid[i]));
                    chk("rsp_Y", i, 8'(ry[i]), 8'(r[3:0]));
                    chk("rsp_carry", i, 8'(rc[i]), 8'(r[4]));
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            ok = !bz[0] && !bz[1];
        end
        chk("idle_timeout", 0, 8'(ok), 8'd1);
    endtask

    task automatic req0_op(int i, logic [3:0] a, logic [3:0] b, logic [2:0] s, logic [3:0] y, logic c);
        bit ok = 0;
        a0 = a; b0 = b; s0 = s; v0 = 1; rr = 1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = rdy0[i];
        end
        chk("accept_timeout", i, 8'(ok), 8'd1);
        @(posedge clk); #1;
        v0 = 0;
        repeat (ec(i)) begin
            @(negedge clk);
            chk("lat_early", i, 8'(rv[i]), 8'd0);
        end
        @(negedge clk);
        chk("lat_valid", i, 8'(rv[i]), 8'd1);
        chk("lit_Y", i, 8'(ry[i]), 8'(y));
        chk("lit_carry", i, 8'(rc[i]), 8'(c));
        chk("lit_id", i, 8'(rid[i]), 8'd0);
        wait_idle();
    endtask

    initial begin
        bit ids [4];
        logic [3:0] ys [4];
        int got, seen;
        bit k0, k1;
        rst = 1; v0 = 1; a0 = 4'd5; b0 = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready0", i, 8'(rdy0[i]), 8'd0);
            chk("rst_valid", i, 8'(rv[i]), 8'd0);
            chk("rst_alu_A", i, 8'(aa[i]), 8'd0);
            chk("rst_alu_B", i, 8'(ab[i]), 8'd0);
            chk("rst_alu_sel", i, 8'(asl[i]), 8'd0);
            chk("rst_busy", i, 8'(bz[i]), 8'd0);
        end
        v0 = 0; rst = 0;
        @(posedge clk); #1;
        req0_op(0, 4'd5, 4'd3, 3'd0, 4'd8, 1'b0);
        req0_op(0, 4'd15, 4'd1, 3'd0, 4'd0, 1'b1);
        req0_op(1, 4'd5, 4'd3, 3'd0, 4'd8, 1'b0);
        // both requesters valid continuously
        @(posedge clk); #1;
        v0 = 1; a0 = 4'd5; b0 = 4'd3; s0 = 3'd1;
        v1 = 1; a1 = 4'd5; b1 = 4'd3; s1 = 3'd4;
        got = 0;
        for (int n = 0; n < 60 && got < 4; n++) begin
            @(negedge clk);
            if (rv[0] && rr) begin
                ids[got] = rid[0]; ys[got] = ry[0]; got++;
            end
        end
        chk("contend_count", 0, 8'(got), 8'd4);
        for (int j = 0; j < 4; j++) begin
`ifdef ALU_ARB_RR_EN
            chk("contend_id", j, 8'(ids[j]), 8'(j % 2));
            chk("contend_Y", j, 8'(ys[j]), (j % 2) ? 8'd6 : 8'd2);
`else
            chk("contend_id", j, 8'(ids[j]), 8'd0);
            chk("contend_Y", j, 8'(ys[j]), 8'd2);
`endif
        end
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        wait_idle();
        // response back-pressure
        @(posedge clk); #1;
        rr = 0; v0 = 1; a0 = 4'd7; b0 = 4'd2; s0 = 3'd0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = int'(rv[0]);
        end
        chk("hold_reach", 0, 8'(seen), 8'd1);
        @(posedge clk); #1;
        v1 = 1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 0, 8'(rv[0]), 8'd1);
            chk("hold_Y", 0, 8'(ry[0]), 8'd9);
            chk("hold_id", 0, 8'(rid[0]), 8'd0);
            chk("hold_rdy0", 0, 8'(rdy0[0]), 8'd0);
            chk("hold_rdy1", 0, 8'(rdy1[0]), 8'd0);
            chk("hold_busy", 0, 8'(bz[0]), 8'd1);
            @(posedge clk); #1;
        end
        v0 = 0; v1 = 0; rr = 1;
        wait_idle();
        // reset in the 2nd EXEC cycle of the 3-cycle instance
        @(posedge clk); #1;
        v0 = 1; a0 = 4'd6; b0 = 4'd6; s0 = 3'd0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = int'(rdy0[1]);
        end
        chk("rst_op_accept", 1, 8'(seen), 8'd1);
        @(posedge clk); #1;
        v0 = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(rv[1]);
        end
        chk("discarded_rsp", 1, 8'(seen), 8'd0);
        req0_op(1, 4'd9, 4'd4, 3'd0, 4'd13, 1'b0);
        // randomized traffic, requesters hold until instance 0 accepts
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            k0 = rdy0[0]; k1 = rdy1[0];
            @(posedge clk); #1;
            rst = ($urandom_range(0, 149) == 0);
            rr = ($urandom_range(0, 3) != 0);
            if (!v0 || k0 || rst) begin
                v0 = $urandom_range(0, 1); a0 = 4'($urandom); b0 = 4'($urandom); s0 = 3'($urandom);
            end
            if (!v1 || k1 || rst) begin
                v1 = $urandom_range(0, 1); a1 = 4'($urandom); b1 = 4'($urandom); s1 = 3'($urandom);
            end
        end
        rst = 0; v0 = 0; v1 = 0; rr = 1;
        wait_idle();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
